// File: rtl/pito_mvu_apb_bridge.sv
// Buffers MVU CSR writes from the hart CSR unit and replays each one as a two-phase APB write.
// Slave errors and ACCESS timeouts are latched into sticky flags together with the failing CSR address.
module pito_mvu_apb_bridge #(
  parameter int unsigned FIFO_DEPTH         = 4,
  parameter int unsigned APB_ADDR_W         = 32,
  parameter logic [11:0] MVU_CSR_START_ADDR = 12'hF20,
  parameter int unsigned TIMEOUT_CYCLES     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [11:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  req_ready,
  output logic [APB_ADDR_W-1:0] apb_paddr,
  output logic                  apb_psel,
  output logic                  apb_penable,
  output logic                  apb_pwrite,
  output logic [31:0]           apb_pwdata,
  input  logic                  apb_pready,
  input  logic                  apb_pslverr,
  input  logic                  err_clr,
  output logic                  busy_o,
  output logic                  err_o,
  output logic                  err_timeout_o,
  output logic [11:0]           err_addr_o
);

  localparam int unsigned PW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state;
  logic [11:0]             fifo_addr [FIFO_DEPTH];
  logic [31:0]             fifo_data [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [PW:0]             count;
  logic [TW-1:0]           tcnt;
  logic                    full, empty, push, pop;
  logic [APB_ADDR_W-1:0]   head_paddr;
  logic [31:0]             head_data;

  assign full       = (count == (PW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign req_ready  = !full && !rst;
  // Out-of-range addresses are handshaken but never enqueued.
  assign push       = req_valid && req_ready && (req_addr >= MVU_CSR_START_ADDR);
  assign head_paddr = APB_ADDR_W'(fifo_addr[rd_ptr]);
  assign head_data  = fifo_data[rd_ptr];
  assign busy_o     = !empty || (state != IDLE);

  always_comb begin
    pop = 1'b0;
    if (!empty)
      pop = (state == IDLE) || ((state == ACCESS) && apb_pready);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= req_addr;
      fifo_data[wr_ptr] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      apb_psel      <= 1'b0;
      apb_penable   <= 1'b0;
      apb_pwrite    <= 1'b0;
      apb_paddr     <= '0;
      apb_pwdata    <= '0;
      tcnt          <= '0;
      err_o         <= 1'b0;
      err_timeout_o <= 1'b0;
      err_addr_o    <= '0;
    end else begin
      // Clear first so an error raised in this same cycle overrides it.
      if (err_clr) begin
        err_o         <= 1'b0;
        err_timeout_o <= 1'b0;
        err_addr_o    <= '0;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            state      <= SETUP;
            apb_psel   <= 1'b1;
            apb_pwrite <= 1'b1;
            apb_paddr  <= head_paddr;
            apb_pwdata <= head_data;
            tcnt       <= '0;
          end
        end
        SETUP: begin
          state       <= ACCESS;
          apb_penable <= 1'b1;
        end
        ACCESS: begin
          if (apb_pready) begin
            if (apb_pslverr) begin
              err_o      <= 1'b1;
              err_addr_o <= apb_paddr[11:0];
            end
            if (pop) begin
              state       <= SETUP;
              apb_penable <= 1'b0;
              apb_paddr   <= head_paddr;
              apb_pwdata  <= head_data;
              tcnt        <= '0;
            end else begin
              state       <= IDLE;
              apb_psel    <= 1'b0;
              apb_penable <= 1'b0;
              apb_pwrite  <= 1'b0;
              apb_paddr   <= '0;
              apb_pwdata  <= '0;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (tcnt == TLAST)) begin
            state         <= IDLE;
            apb_psel      <= 1'b0;
            apb_penable   <= 1'b0;
            apb_pwrite    <= 1'b0;
            apb_paddr     <= '0;
            apb_pwdata    <= '0;
            err_o         <= 1'b1;
            err_timeout_o <= 1'b1;
            err_addr_o    <= apb_paddr[11:0];
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pop_on_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: tb/tb_pito_mvu_apb_bridge.sv
// Bench for pito_mvu_apb_bridge: directed vector table, multi-cycle corner sequences,
// and a randomized run scored against an in-order queue model of forwarded writes.
module tb_pito_mvu_apb_bridge;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] apb_paddr;
  logic        apb_psel, apb_penable, apb_pwrite;
  logic [31:0] apb_pwdata;
  logic        apb_pready, apb_pslverr, err_clr;
  logic        busy_o, err_o, err_timeout_o;
  logic [11:0] err_addr_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pito_mvu_apb_bridge #(
    .FIFO_DEPTH(4),
    .APB_ADDR_W(32),
    .MVU_CSR_START_ADDR(12'hF20),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
    .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata),
    .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
    .err_clr(err_clr), .busy_o(busy_o), .err_o(err_o),
    .err_timeout_o(err_timeout_o), .err_addr_o(err_addr_o)
  );

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    int          waits;
    bit          slverr;
    bit          fwd;
  } vec_t;

  vec_t vt [7];
  logic [43:0] q [$];
  logic        mdl_err;
  logic [11:0] mdl_addr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scores a completing APB write against the oldest forwarded request.
  task automatic mon();
    logic [43:0] e;
    if (apb_psel && apb_penable && apb_pready) begin
      if (q.size() == 0) begin
        chk("rnd_unexpected_xfer", 1, 0);
      end else begin
        e = q.pop_front();
        chk("rnd_paddr", apb_paddr, {20'h0, e[43:32]});
        chk("rnd_pwdata", apb_pwdata, e[31:0]);
        if (apb_pslverr) begin
          mdl_err  = 1'b1;
          mdl_addr = e[43:32];
        end
      end
    end
  endtask

  task automatic push_one(input logic [11:0] a, input logic [31:0] d, input logic exp_ready, input string name);
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = d;
    chk(name, req_ready, exp_ready);
    step();
    req_valid = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_err", err_o, 0);
    chk("clr_err_to", err_timeout_o, 0);
    chk("clr_err_addr", err_addr_o, 0);
  endtask

  initial begin
    int n;
    bit seen_psel, seen_busy, lowrun_ok;
    int lowrun;

    vt[0] = '{12'hF21, 32'hDEADBEEF, 0, 1'b0, 1'b1};
    vt[1] = '{12'h300, 32'h11111111, 0, 1'b0, 1'b0};
    vt[2] = '{12'hF30, 32'hCAFEF00D, 0, 1'b1, 1'b1};
    vt[3] = '{12'hF25, 32'h0BADC0DE, 3, 1'b0, 1'b1};
    vt[4] = '{12'hF20, 32'h00000020, 1, 1'b0, 1'b1};
    vt[5] = '{12'hF1F, 32'h0000001F, 0, 1'b0, 1'b0};
    vt[6] = '{12'hFFF, 32'hFFFF0001, 2, 1'b1, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    apb_pready = 1'b0; apb_pslverr = 1'b0; err_clr = 1'b0;
    mdl_err = 1'b0; mdl_addr = '0;
    step();
    chk("rst_psel", apb_psel, 0);
    chk("rst_penable", apb_penable, 0);
    chk("rst_paddr", apb_paddr, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_req_ready", req_ready, 0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      push_one(vt[i].addr, vt[i].data, 1'b1, "tbl_req_ready");
      if (vt[i].fwd) begin
        step();
        chk("tbl_setup_psel", apb_psel, 1);
        chk("tbl_setup_penable", apb_penable, 0);
        chk("tbl_setup_pwrite", apb_pwrite, 1);
        chk("tbl_setup_paddr", apb_paddr, {20'h0, vt[i].addr});
        chk("tbl_setup_pwdata", apb_pwdata, vt[i].data);
        step();
        for (int w = 0; w <= vt[i].waits; w++) begin
          apb_pready  = (w == vt[i].waits);
          apb_pslverr = vt[i].slverr && (w == vt[i].waits);
          chk("tbl_access_penable", apb_penable, 1);
          chk("tbl_access_paddr", apb_paddr, {20'h0, vt[i].addr});
          chk("tbl_access_pwdata", apb_pwdata, vt[i].data);
          step();
        end
        apb_pready = 1'b0;
        apb_pslverr = 1'b0;
        chk("tbl_done_psel", apb_psel, 0);
        chk("tbl_done_busy", busy_o, 0);
        chk("tbl_done_err", err_o, vt[i].slverr);
        chk("tbl_done_err_to", err_timeout_o, 0);
        chk("tbl_done_err_addr", err_addr_o, vt[i].slverr ? vt[i].addr : 12'h000);
        if (vt[i].slverr) clear_err();
      end else begin
        seen_psel = 1'b0;
        seen_busy = 1'b0;
        for (int c = 0; c < 10; c++) begin
          seen_psel |= apb_psel;
          seen_busy |= busy_o;
          step();
        end
        chk("tbl_drop_psel", seen_psel, 0);
        chk("tbl_drop_busy", seen_busy, 0);
      end
    end

    // Back-to-back and full: one transfer parked in ACCESS, then fill the FIFO.
    apb_pready = 1'b0;
    push_one(12'hF40, 32'h0, 1'b1, "b2b_first_ready");
    step();
    step();
    chk("b2b_parked_access", apb_penable, 1);
    for (int k = 1; k <= 5; k++)
      push_one(12'hF40 + 12'(k), 32'(k), (k <= 4), "b2b_req_ready");
    apb_pready = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) begin
      chk("b2b_setup_psel", apb_psel, 1);
      chk("b2b_setup_penable", apb_penable, 0);
      chk("b2b_setup_pwdata", apb_pwdata, 32'(k));
      step();
      chk("b2b_access_penable", apb_penable, 1);
      chk("b2b_access_pwdata", apb_pwdata, 32'(k));
      step();
    end
    chk("b2b_idle_psel", apb_psel, 0);
    chk("b2b_idle_busy", busy_o, 0);
    apb_pready = 1'b0;

    // Timeout: pready stuck low.
    push_one(12'hF50, 32'h5050, 1'b1, "to_req_ready");
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (apb_penable) n++;
    end
    chk("to_access_cycles", n, 8);
    chk("to_psel_low", apb_psel, 0);
    chk("to_err", err_o, 1);
    chk("to_err_to", err_timeout_o, 1);
    chk("to_err_addr", err_addr_o, 12'hF50);

    // Later pslverr keeps the timeout flag and reloads the address.
    push_one(12'hF51, 32'h5151, 1'b1, "to2_req_ready");
    step();
    apb_pready = 1'b1;
    apb_pslverr = 1'b1;
    step();
    step();
    apb_pready = 1'b0;
    apb_pslverr = 1'b0;
    chk("to2_err_to_sticky", err_timeout_o, 1);
    chk("to2_err_addr", err_addr_o, 12'hF51);
    clear_err();

    // Reset during ACCESS with two entries queued.
    push_one(12'hF60, 32'h60, 1'b1, "rst_push0");
    push_one(12'hF61, 32'h61, 1'b1, "rst_push1");
    push_one(12'hF62, 32'h62, 1'b1, "rst_push2");
    chk("rst_mid_access", apb_penable, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_req_ready", req_ready, 0);
    step();
    chk("rst_mid_psel", apb_psel, 0);
    chk("rst_mid_penable", apb_penable, 0);
    chk("rst_mid_pwrite", apb_pwrite, 0);
    chk("rst_mid_paddr", apb_paddr, 0);
    chk("rst_mid_pwdata", apb_pwdata, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_err", err_o, 0);
    rst = 1'b0;
    apb_pready = 1'b1;
    seen_psel = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      seen_psel |= apb_psel;
    end
    chk("rst_mid_queue_lost", seen_psel, 0);

    // Randomized traffic against the queue model.
    mdl_err = 1'b0;
    mdl_addr = '0;
    lowrun = 0;
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_addr  = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 32'hF1F))
                                             : 12'($urandom_range(32'hF20, 32'hFFF));
      req_wdata = $urandom;
      lowrun_ok = (lowrun < 4);
      apb_pready = lowrun_ok ? ($urandom_range(0, 2) != 0) : 1'b1;
      lowrun = apb_pready ? 0 : lowrun + 1;
      apb_pslverr = ($urandom_range(0, 3) == 0);
      #1;
      if (req_valid && req_ready && (req_addr >= 12'hF20))
        q.push_back({req_addr, req_wdata});
      mon();
      step();
    end
    req_valid = 1'b0;
    apb_pready = 1'b1;
    apb_pslverr = 1'b0;
    n = 0;
    while (busy_o && n < 100) begin
      mon();
      step();
      n++;
    end
    chk("rnd_drain_busy", busy_o, 0);
    chk("rnd_queue_empty", q.size(), 0);
    chk("rnd_err", err_o, mdl_err);
    chk("rnd_err_to", err_timeout_o, 0);
    chk("rnd_err_addr", err_addr_o, mdl_addr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
